// File: rtl/lives_controller.sv
// lives_controller: life count, hit/restart sequencing, invulnerability window and blink for the heart display.
// Ports: clk, reset (sync, active-high), frame_tick, hit, extra_life, restart in;
//        lives[1:0], display_lives[1:0], invulnerable, life_lost, game_over out.
// Optional: define LIVES_EXTRA_LIFE_EN to make extra_life grant a life (saturating at MAX_LIVES).
module lives_controller #(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       extra_life,
  input  logic       restart,
  output logic [1:0] lives,
  output logic [1:0] display_lives,
  output logic       invulnerable,
  output logic       life_lost,
  output logic       game_over
);
  localparam int CW = INVULN_FRAMES > 1 ? $clog2(INVULN_FRAMES) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [1:0] ML = 2'(MAX_LIVES);
  localparam logic [CW-1:0] C_LAST = CW'(INVULN_FRAMES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);
  typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} state_t;
  state_t state, state_n;
  logic [1:0] lives_n, disp_n, lives_inc;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic blink, blink_n, lost_n, ext;
`ifdef LIVES_EXTRA_LIFE_EN
  assign ext = extra_life;
`else
  logic unused_extra;
  assign unused_extra = extra_life;
  assign ext = 1'b0;
`endif
  assign lives_inc = lives == ML ? lives : lives + 2'd1;
  always_comb begin
    state_n = state;
    lives_n = lives;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    blink_n = blink;
    lost_n  = 1'b0;
    if (restart) begin
      state_n = PLAY;
      lives_n = ML;
      cnt_n   = '0;
      bcnt_n  = '0;
      blink_n = 1'b0;
    end else if (state == PLAY) begin
      if (hit && lives != 2'd0) begin
        lives_n = lives - 2'd1;
        lost_n  = 1'b1;
        state_n = lives == 2'd1 ? GAME_OVER : INVULN;
        cnt_n   = '0;
        bcnt_n  = '0;
        blink_n = lives != 2'd1;
      end else if (ext) begin
        lives_n = lives_inc;
      end
    end else if (state == INVULN) begin
      if (ext) lives_n = lives_inc;
      if (frame_tick) begin
        if (cnt == C_LAST) begin
          state_n = PLAY;
          cnt_n   = '0;
          bcnt_n  = '0;
          blink_n = 1'b0;
        end else begin
          cnt_n   = cnt + 1'b1;
          bcnt_n  = bcnt == B_LAST ? '0 : bcnt + 1'b1;
          blink_n = blink ^ (bcnt == B_LAST);
        end
      end
    end
    // A life regained during the window can leave no missing heart to flash.
    disp_n = (state_n == INVULN && blink_n && lives_n != ML) ? lives_n + 2'd1 : lives_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PLAY;
      lives         <= ML;
      display_lives <= ML;
      cnt           <= '0;
      bcnt          <= '0;
      blink         <= 1'b0;
      life_lost     <= 1'b0;
    end else begin
      state         <= state_n;
      lives         <= lives_n;
      display_lives <= disp_n;
      cnt           <= cnt_n;
      bcnt          <= bcnt_n;
      blink         <= blink_n;
      life_lost     <= lost_n;
    end
  end
  assign invulnerable = state == INVULN;
  assign game_over    = state == GAME_OVER;
endmodule
